// File: rtl/vec_cache_rd_data_master_arb.sv
// Read-data master router for the vector cache response path.
// M upstream read-data sources are steered by txn_id.master_id into N
// one-entry registered output slots. Each slot has its own round-robin
// arbiter, so sources that collide on one master are served in turn and
// the losers are simply held off (never dropped).

package vec_cache_rd_pkg;

  typedef struct packed {
    logic [7:0] master_id;
    logic [7:0] seq;
  } txn_id_t;

  typedef struct packed {
    txn_id_t     txn_id;
    logic [31:0] data;
  } us_data_pld_t;

endpackage

// Handshake: a beat moves on a channel in a cycle where vld && rdy are both
// high at the rising edge. A source must hold vld/pld stable until it sees
// rdy. in_rdy is combinational from in_vld/in_pld/out_rdy and the current
// slot state; out_vld/out_pld are registered. A slot may be drained and
// refilled in the same cycle.
module vec_cache_rd_data_master_arb
  import vec_cache_rd_pkg::*;
#(
  parameter int M     = 8,
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M-1:0]     in_vld,
  output logic [M-1:0]     in_rdy,
  input  us_data_pld_t     in_pld [M],
  output logic [N-1:0]     out_vld,
  input  logic [N-1:0]     out_rdy,
  output us_data_pld_t     out_pld [N],
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             err_bad_id
);

  localparam int IDW = $clog2(N);
  localparam int PW  = $clog2(M);
  // Slot count widened by one bit so the out-of-range test has room for N.
  localparam logic [IDW:0]   N_EXT   = (IDW+1)'(N);
  localparam logic [PW-1:0]  LAST_SRC = PW'(M - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // State
  logic [N-1:0]     out_vld_q, out_vld_d;
  us_data_pld_t     out_pld_q [N];
  us_data_pld_t     out_pld_d [N];
  logic [PW-1:0]    ptr_q [N];
  logic [PW-1:0]    ptr_d [N];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Decode / arbitration nets
  logic [IDW-1:0]   key [M];
  logic [M-1:0]     bad;
  logic [M-1:0]     req [N];
  logic [N-1:0]     ld_ok;
  logic [N-1:0]     gnt;
  logic [PW-1:0]    gnt_idx [N];
  logic [M-1:0]     in_rdy_c;
  logic             any_conflict;

  // Extract routing key per source and flag keys that name no slot.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      key[i] = in_pld[i].txn_id.master_id[IDW-1:0];
      bad[i] = in_vld[i] && ({1'b0, key[i]} >= N_EXT);
    end
  end

  // Build the request matrix; bad-id beats and reset cycles request nothing.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < M; i++) begin
        req[j][i] = !rst && in_vld[i] && !bad[i] && (key[i] == IDW'(j));
      end
    end
  end

  // Per-slot round-robin pick starting at ptr, gated by slot availability.
  always_comb begin
    int idx;
    idx          = 0;
    gnt          = '0;
    in_rdy_c     = '0;
    any_conflict = 1'b0;
    for (int j = 0; j < N; j++) begin
      gnt_idx[j] = '0;
      ld_ok[j]   = !out_vld_q[j] || out_rdy[j];
      if ($countones(req[j]) > 1) any_conflict = 1'b1;
      for (int k = 0; k < M; k++) begin
        idx = (int'(ptr_q[j]) + k) % M;
        if (!gnt[j] && ld_ok[j] && req[j][idx]) begin
          gnt[j]     = 1'b1;
          gnt_idx[j] = PW'(idx);
        end
      end
      if (gnt[j]) in_rdy_c[gnt_idx[j]] = 1'b1;
    end
    // Bad-id beats are swallowed immediately so the source never stalls.
    for (int i = 0; i < M; i++) begin
      if (bad[i]) in_rdy_c[i] = 1'b1;
    end
  end

  assign in_rdy = rst ? '0 : in_rdy_c;

  // Next-state for slots, pointers, conflict counter and error pulse.
  always_comb begin
    out_vld_d = out_vld_q;
    for (int j = 0; j < N; j++) begin
      out_pld_d[j] = out_pld_q[j];
      ptr_d[j]     = ptr_q[j];
      if (gnt[j]) begin
        out_vld_d[j] = 1'b1;
        out_pld_d[j] = in_pld[gnt_idx[j]];
        ptr_d[j]     = (gnt_idx[j] == LAST_SRC) ? '0 : gnt_idx[j] + 1'b1;
      end else if (out_rdy[j]) begin
        // Drain only; payload is left as-is.
        out_vld_d[j] = 1'b0;
      end
    end
    cnt_d = cnt_q;
    if (any_conflict && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    err_d = |bad;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= '0;
      for (int j = 0; j < N; j++) begin
        out_pld_q[j] <= '0;
        ptr_q[j]     <= '0;
      end
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      for (int j = 0; j < N; j++) begin
        out_pld_q[j] <= out_pld_d[j];
        ptr_q[j]     <= ptr_d[j];
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign out_pld      = out_pld_q;
  assign conflict_cnt = cnt_q;
  assign err_bad_id   = err_q;

endmodule

// File: tb/tb_vec_cache_rd_data_master_arb.sv
// Bench for vec_cache_rd_data_master_arb (M=8, N=12, CNT_W=4).
// A reference model of the router runs alongside the DUT and is compared
// every cycle; directed scenarios add literal expectations.
module tb_vec_cache_rd_data_master_arb;
  import vec_cache_rd_pkg::*;

  localparam int M     = 8;
  localparam int N     = 12;
  localparam int CNT_W = 4;
  localparam int IDW   = $clog2(N);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [M-1:0]     in_vld = '0;
  logic [M-1:0]     in_rdy;
  us_data_pld_t     in_pld [M];
  logic [N-1:0]     out_vld;
  logic [N-1:0]     out_rdy = '1;
  us_data_pld_t     out_pld [N];
  logic [CNT_W-1:0] conflict_cnt;
  logic             err_bad_id;

  vec_cache_rd_data_master_arb #(.M(M), .N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_pld       (in_pld),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_pld      (out_pld),
    .conflict_cnt (conflict_cnt),
    .err_bad_id   (err_bad_id)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic us_data_pld_t mk(input int src, input int mid, input logic [31:0] data);
    us_data_pld_t p;
    p.txn_id.master_id = 8'(mid);
    p.txn_id.seq       = 8'(src);
    p.data             = data;
    return p;
  endfunction

  // ---------------- driver ----------------
  // Main process posts one beat per source; the driver presents it and
  // retires it once accepted. Each side owns its own counter.
  int           push_cnt [M];
  int           done_cnt [M];
  us_data_pld_t pend_pld [M];
  logic [M-1:0] acc = '0;

  initial begin
    for (int i = 0; i < M; i++) begin
      push_cnt[i] = 0;
      pend_pld[i] = '0;
      in_pld[i]   = '0;
    end
  end

  initial begin
    for (int i = 0; i < M; i++) done_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < M; i++) begin
        if (acc[i]) done_cnt[i]++;
        in_vld[i] = (push_cnt[i] != done_cnt[i]);
        in_pld[i] = pend_pld[i];
      end
    end
  end

  task automatic push(input int src, input int mid, input logic [31:0] data);
    chk("push_src_idle", 64'(push_cnt[src] - done_cnt[src] - int'(acc[src])), 64'd0);
    pend_pld[src] = mk(src, mid, data);
    push_cnt[src]++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- reference model + compare ----------------
  logic [N-1:0] m_vld = '0;
  us_data_pld_t m_pld [N];
  int           m_ptr [N];
  int           m_cnt = 0;
  logic         m_err = 1'b0;

  initial begin
    for (int j = 0; j < N; j++) begin
      m_pld[j] = '0;
      m_ptr[j] = 0;
    end
  end

  always @(negedge clk) begin
    logic [M-1:0] exp_rdy;
    logic         conflict;
    logic         bad_seen;
    int           cands[$];
    int           win;
    int           best;
    int           key;

    if (started) begin
      chk("out_vld", 64'(out_vld), 64'(m_vld));
      for (int j = 0; j < N; j++) chk($sformatf("out_pld[%0d]", j), 64'(out_pld[j]), 64'(m_pld[j]));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      chk("err_bad_id", 64'(err_bad_id), 64'(m_err));
    end

    exp_rdy = '0;
    if (rst) begin
      m_vld = '0;
      for (int j = 0; j < N; j++) begin
        m_pld[j] = '0;
        m_ptr[j] = 0;
      end
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      conflict = 1'b0;
      bad_seen = 1'b0;
      for (int i = 0; i < M; i++) begin
        key = int'(in_pld[i].txn_id.master_id[IDW-1:0]);
        if (in_vld[i] && key >= N) begin
          exp_rdy[i] = 1'b1;
          bad_seen   = 1'b1;
        end
      end
      for (int j = 0; j < N; j++) begin
        cands.delete();
        for (int i = 0; i < M; i++) begin
          key = int'(in_pld[i].txn_id.master_id[IDW-1:0]);
          if (in_vld[i] && key == j) cands.push_back(i);
        end
        if (cands.size() >= 2) conflict = 1'b1;
        if (cands.size() > 0 && (!m_vld[j] || out_rdy[j])) begin
          // Winner: requester closest to the pointer going forward.
          win  = cands[0];
          best = M;
          foreach (cands[c]) begin
            if (((cands[c] - m_ptr[j] + M) % M) < best) begin
              best = (cands[c] - m_ptr[j] + M) % M;
              win  = cands[c];
            end
          end
          exp_rdy[win] = 1'b1;
          m_vld[j]     = 1'b1;
          m_pld[j]     = in_pld[win];
          m_ptr[j]     = (win + 1) % M;
        end else if (out_rdy[j]) begin
          m_vld[j] = 1'b0;
        end
      end
      if (conflict && m_cnt < CNT_MAX) m_cnt++;
      m_err = bad_seen;
    end

    if (started) chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    acc = in_vld & in_rdy;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst     = 1'b1;
    out_rdy = '1;
    step();
    step();
    started = 1'b1;

    // Reset state, and a beat held through reset is taken right after.
    push(0, 9, 32'h1111_0000);
    sample();
    chk("rst_in_rdy", 64'(in_rdy), 64'h0);
    chk("rst_out_vld", 64'(out_vld), 64'h0);
    chk("rst_cnt", 64'(conflict_cnt), 64'h0);
    chk("rst_err", 64'(err_bad_id), 64'h0);
    step();
    rst = 1'b0;
    sample();
    chk("post_rst_in_rdy", 64'(in_rdy), 64'h01);
    step();
    sample();
    chk("post_rst_out_vld9", 64'(out_vld[9]), 64'h1);
    step();
    step();

    // Single beat: source 3 -> master 5.
    push(3, 5, 32'hA5A5_0003);
    sample();
    chk("single_in_rdy", 64'(in_rdy), 64'h08);
    step();
    sample();
    chk("single_out_vld5", 64'(out_vld[5]), 64'h1);
    chk("single_pld5", 64'(out_pld[5]), 64'(mk(3, 5, 32'hA5A5_0003)));
    chk("single_cnt", 64'(conflict_cnt), 64'h0);
    step();
    step();

    // Three-way collision on master 4: grants 0, 2, 7.
    push(0, 4, 32'hC0C0_0000);
    push(2, 4, 32'hC0C0_0002);
    push(7, 4, 32'hC0C0_0007);
    sample();
    chk("coll_gnt0", 64'(in_rdy), 64'h01);
    step();
    sample();
    chk("coll_gnt2", 64'(in_rdy), 64'h04);
    chk("coll_pld_0", 64'(out_pld[4]), 64'(mk(0, 4, 32'hC0C0_0000)));
    step();
    sample();
    chk("coll_gnt7", 64'(in_rdy), 64'h80);
    chk("coll_pld_2", 64'(out_pld[4]), 64'(mk(2, 4, 32'hC0C0_0002)));
    step();
    sample();
    chk("coll_pld_7", 64'(out_pld[4]), 64'(mk(7, 4, 32'hC0C0_0007)));
    chk("coll_cnt", 64'(conflict_cnt), 64'h2);
    step();
    push(7, 4, 32'hD0D0_0007);
    sample();
    chk("coll_single7", 64'(in_rdy), 64'h80);
    step();
    push(0, 4, 32'hE0E0_0000);
    push(2, 4, 32'hE0E0_0002);
    push(7, 4, 32'hE0E0_0007);
    sample();
    chk("coll_wrap_gnt0", 64'(in_rdy), 64'h01);
    repeat (4) step();

    // Backpressure on master 1.
    out_rdy[1] = 1'b0;
    push(5, 1, 32'hF0F0_0005);
    sample();
    chk("bp_fill", 64'(in_rdy), 64'h20);
    step();
    push(6, 1, 32'hF1F1_0006);
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("bp_stall_rdy6", 64'(in_rdy[6]), 64'h0);
      chk("bp_stall_pld", 64'(out_pld[1]), 64'(mk(5, 1, 32'hF0F0_0005)));
      step();
    end
    out_rdy[1] = 1'b1;
    sample();
    chk("bp_release_rdy", 64'(in_rdy), 64'h40);
    step();
    sample();
    chk("bp_next_pld", 64'(out_pld[1]), 64'(mk(6, 1, 32'hF1F1_0006)));
    step();
    step();

    // Parallel routing: source i -> master i.
    for (int i = 0; i < M; i++) push(i, i, 32'hC000_0000 + 32'(i));
    sample();
    chk("par_in_rdy", 64'(in_rdy), 64'hFF);
    step();
    sample();
    chk("par_out_vld", 64'(out_vld[7:0]), 64'hFF);
    step();
    step();

    // Bad id: master 13 does not exist with N=12.
    push(2, 13, 32'hBAD0_0013);
    sample();
    chk("bad_in_rdy", 64'(in_rdy), 64'h04);
    step();
    sample();
    chk("bad_err_pulse", 64'(err_bad_id), 64'h1);
    chk("bad_no_out", 64'(out_vld), 64'h0);
    step();
    sample();
    chk("bad_err_clear", 64'(err_bad_id), 64'h0);
    chk("bad_no_out2", 64'(out_vld), 64'h0);
    step();

    // Reset mid-stream with three held slots and ptr[4] moved to 4.
    out_rdy[2:0] = 3'b000;
    push(0, 0, 32'h5100_0000);
    push(1, 1, 32'h5100_0001);
    push(2, 2, 32'h5100_0002);
    push(3, 4, 32'h5100_0003);
    sample();
    chk("mid_in_rdy", 64'(in_rdy), 64'h0F);
    step();
    sample();
    chk("mid_held", 64'(out_vld[2:0]), 64'h7);
    step();
    rst = 1'b1;
    sample();
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'h0);
    step();
    rst     = 1'b0;
    out_rdy = '1;
    push(2, 4, 32'h5200_0002);
    push(5, 4, 32'h5200_0005);
    sample();
    chk("mid_out_vld_clr", 64'(out_vld), 64'h0);
    chk("mid_cnt_clr", 64'(conflict_cnt), 64'h0);
    chk("mid_pld0_clr", 64'(out_pld[0]), 64'h0);
    chk("mid_ptr_reset", 64'(in_rdy), 64'h04);
    step();
    sample();
    chk("mid_second", 64'(in_rdy), 64'h20);
    chk("mid_cnt_one", 64'(conflict_cnt), 64'h1);
    step();
    step();

    // Saturation: hold master 8 full while two sources fight for it.
    out_rdy[8] = 1'b0;
    push(4, 8, 32'h5A70_0004);
    step();
    push(0, 8, 32'h5A70_0000);
    push(1, 8, 32'h5A70_0001);
    repeat (20) step();
    sample();
    chk("sat_cnt", 64'(conflict_cnt), 64'(CNT_MAX));
    step();
    out_rdy[8] = 1'b1;
    repeat (6) step();

    begin
      int pend;
      pend = 0;
      for (int i = 0; i < M; i++) pend += push_cnt[i] - done_cnt[i];
      chk("all_beats_taken", 64'(pend), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vec_cache_rd_data_master_arb.md
# vec_cache_rd_data_master_arb

Registered, arbitrating router for upstream read-data beats in the vector cache response path. Each of M read-data sources presents a `us_data_pld_t` beat tagged with `txn_id.master_id`, and the block delivers it to one of N master-side output channels. When several sources target the same master in one cycle, a per-master round-robin arbiter picks one winner and backpressures the rest, so no beat is lost. Every output is a one-entry registered slot with valid/ready handshake.

## Interface
- `M`, default 8: number of read-data source channels.
- `N`, default 16: number of master output channels; `IDW = $clog2(N)` is the routing index width.
- `CNT_W`, default 16: width of the conflict counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_vld`  in  M  source beat valid.
- `in_rdy`  out  M  source beat accepted this cycle.
- `in_pld`  in  `us_data_pld_t` [M]  source beat; routing key is `txn_id.master_id[IDW-1:0]`.
- `out_vld`  out  N  master slot holds a beat.
- `out_rdy`  in  N  master consumes the slot beat.
- `out_pld`  out  `us_data_pld_t` [N]  slot beat.
- `conflict_cnt`  out  CNT_W  saturating count of cycles in which any master had two or more requesters.
- `err_bad_id`  out  1  one-cycle pulse when a beat with `master_id >= N` is accepted.

## Operation
- Request matrix: `req[j][i] = in_vld[i] && (master_id_i == j)`. Exactly one target per source.
- Slot j can load (`ld_ok[j]`) when `!out_vld[j] || out_rdy[j]`. This gives full throughput: drain and refill happen in the same cycle.
- Arbiter per master j uses round-robin pointer `ptr[j]` (width `$clog2(M)`, reset 0). The grant goes to the first requesting i scanning `ptr[j], ptr[j]+1, …, M-1, 0, …`, wrapping modulo M. A grant is issued only if `ld_ok[j]`.
- On a grant to i:
  - slot j loads `in_pld[i]`, and `out_vld[j]` is set to 1;
  - `ptr[j]` becomes `(i+1) mod M`.
- If no grant is issued to j, `ptr[j]` holds.
- If `out_rdy[j]` and no grant, `out_vld[j]` is cleared and `out_pld[j]` holds its old value.
- `in_rdy[i]` = 1 iff source i won its target's arbitration this cycle. It is combinational from `in_vld`, `in_pld` and `out_rdy`. Sources must hold `in_vld`/`in_pld` stable until accepted.
- Bad id (`master_id >= N`, possible only when N is not a power of 2):
  - `in_rdy[i]=1` immediately and the beat is discarded;
  - `err_bad_id` pulses high on the next cycle (registered OR over all such sources);
  - the beat never competes for any slot.
- Conflict counter: increments by 1 in any cycle where some j has ≥2 set bits in `req[j][*]`. It saturates at `2^CNT_W-1`. Rejected requesters are re-counted on each cycle they keep conflicting.
- Different masters are fully independent. Up to min(M,N) beats can move per cycle.

## Timing
- Reset values:
  - `out_vld=0`, `out_pld='0`, all `ptr=0`, `conflict_cnt=0`, `err_bad_id=0`;
  - `in_rdy` follows the reset-state logic: slots are empty, so an uncontested valid source sees `in_rdy=1` in the cycle after `rst` deasserts.
- During `rst=1`, `in_rdy=0` for all sources and no beat is accepted.
- Reset asserted mid-operation discards slot contents with no output handshake. Sources holding unaccepted beats retry after reset.
- Latency: a beat accepted in cycle t (`in_vld&in_rdy`) appears with `out_vld=1` in cycle t+1. If the master asserts `out_rdy` in t+1, the slot refills in t+1 and the next beat appears in t+2.
- A stalled slot (`out_vld=1`, `out_rdy=0`):
  - `out_pld` is held stable;
  - all requesters to that master see `in_rdy=0`;
  - the pointer does not advance.
- Fairness: with k persistent requesters to one master and `out_rdy` held high, each source is granted exactly once every k consecutive grants.

## Test plan
- Single beat: reset, then source 3 sends master_id=5 with `out_rdy[5]=1`. Required: `in_rdy[3]=1` in cycle 0, `out_vld[5]=1` with matching payload in cycle 1, `conflict_cnt=0`.
- Collision rotation: sources 0, 2 and 7 hold beats for master 4, with `out_rdy[4]=1`. Required: grants in order 0, 2, 7 on three consecutive cycles, one output per cycle, `conflict_cnt=2`. After a later single request from 7, the next three-way collision grants 0 first, because `ptr[4]` wrapped to 0.
- Backpressure: fill master 1 and hold `out_rdy[1]=0` for 5 cycles while source 6 requests master 1. Required: `out_pld[1]` is stable, `in_rdy[6]=0` for 5 cycles, and the beat is accepted in the same cycle `out_rdy[1]` rises.
- Parallel routing: all M=8 sources target distinct masters 0..7 in one cycle. Required: all `in_rdy=1`, and all 8 slots are valid the next cycle.
- Bad id and saturation: with N=12, source 2 sends master_id=13. Required: `in_rdy[2]=1`, `err_bad_id=1` for one cycle, and no `out_vld` asserts. Separately, with CNT_W=4 and 20 conflicting cycles, `conflict_cnt` stays at 15.
- Reset mid-stream: assert `rst` while 3 slots are valid. Required: every `out_vld=0` the next cycle, and all pointers and the counter return to 0.
